// File: rtl/uart_mmio_fifo_pkg.sv
// Shared definitions for the memory-mapped UART port: read-select encodings and data width.
// Also imported by the Control decode so both sides agree on UARTsel values.
package uart_mmio_fifo_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] SEL_RXDATA = 2'b00;
    localparam logic [1:0] SEL_TXRDY  = 2'b01;
    localparam logic [1:0] SEL_RXVLD  = 2'b10;
    localparam logic [1:0] SEL_STATS  = 2'b11;

    // Status reads return a single flag in bit 0.
    function automatic logic [31:0] flag_word(input logic flag);
        return {31'b0, flag};
    endfunction

endpackage

// File: rtl/uart_mmio_fifo_if.sv
// Bus bundle for uart_mmio_fifo: CPU-side MMIO controls plus the serial TX/RX byte handshakes.
// master = CPU/serial environment, slave = the UART port itself.
interface uart_mmio_fifo_if;

    logic        WEUART;
    logic        REUART;
    logic [1:0]  UARTsel;
    logic [7:0]  WriteData;
    logic [31:0] ReadData;
    logic [7:0]  DataIn;
    logic        DataInValid;
    logic        DataInReady;
    logic [7:0]  DataOut;
    logic        DataOutValid;
    logic        DataOutReady;

    modport master (
        output WEUART, REUART, UARTsel, WriteData, DataInReady, DataOut, DataOutValid,
        input  ReadData, DataIn, DataInValid, DataOutReady
    );

    modport slave (
        input  WEUART, REUART, UARTsel, WriteData, DataInReady, DataOut, DataOutValid,
        output ReadData, DataIn, DataInValid, DataOutReady
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy counter; push while full and pop while empty are ignored.
// Head entry is visible on dout without a read strobe (no bypass from din).
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the counter alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART port: TX/RX byte FIFOs between CPU and serial side, registered read mux.
// Define UART_STATS_EN to build the sent/received counters and the sticky TX-drop flag.
module uart_mmio_fifo
    import uart_mmio_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_mmio_fifo_if.slave   bus
);

    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_dout, rx_dout;
    logic              tx_pop, rx_push;
    logic [31:0]       stats;
    logic [31:0]       rdata_d, rdata_q;

    // Held low during reset so the receiver never hands over a byte that would be lost.
    assign bus.DataOutReady = reset_n && !rx_full;
    assign rx_push          = bus.DataOutValid && bus.DataOutReady;
    assign tx_pop           = !tx_empty && bus.DataInReady;

    assign bus.DataIn      = tx_dout;
    assign bus.DataInValid = !tx_empty;
    assign bus.ReadData    = rdata_q;

    uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.WEUART),
        .pop     (bus.DataInReady),
        .din     (bus.WriteData),
        .dout    (tx_dout),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (bus.REUART),
        .din     (bus.DataOut),
        .dout    (rx_dout),
        .full    (rx_full),
        .empty   (rx_empty)
    );

`ifdef UART_STATS_EN
    logic [14:0] tx_sent_q;
    logic [15:0] rx_recv_q;
    logic        tx_drop_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sent_q <= '0;
            rx_recv_q <= '0;
            tx_drop_q <= 1'b0;
        end else begin
            if (tx_pop && (tx_sent_q != '1))  tx_sent_q <= tx_sent_q + 15'd1;
            if (rx_push && (rx_recv_q != '1)) rx_recv_q <= rx_recv_q + 16'd1;
            if (bus.WEUART && tx_full)        tx_drop_q <= 1'b1;
        end
    end

    assign stats = {tx_drop_q, tx_sent_q, rx_recv_q};
`else
    assign stats = 32'h0;
`endif

    // Head is captured before any pop on the same edge, so a REUART returns the popped byte.
    always_comb begin
        rdata_d = '0;
        unique case (bus.UARTsel)
            SEL_RXDATA: rdata_d = rx_empty ? 32'h0 : {24'b0, rx_dout};
            SEL_TXRDY:  rdata_d = flag_word(!tx_full);
            SEL_RXVLD:  rdata_d = flag_word(!rx_empty);
            SEL_STATS:  rdata_d = stats;
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

endmodule
